// File: rtl/key_pio_debounce.sv
// Avalon-MM input PIO for the board pushbuttons: 2-flop synchroniser, per-bit
// debounce, edge detect, write-1-to-clear edge capture and a maskable level irq.
module key_pio_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned EDGE_MODE       = 1,
    parameter bit          RESET_LEVEL     = 1'b1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] key_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    localparam int unsigned DATA_W = 32;
    localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_LEVEL}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    logic [WIDTH-1:0]  sync1_q, sync1_d;
    logic [WIDTH-1:0]  sync2_q, sync2_d;
    logic [WIDTH-1:0]  stable_q, stable_d;
    logic [WIDTH-1:0]  stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0]  cnt_q [WIDTH];
    logic [CNT_W-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0]  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]  edgecap_q, edgecap_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              irq_q, irq_d;

    logic [WIDTH-1:0]  rise_c, fall_c, edge_sel_c, clr_c;
    logic              unused_wdata;

    // Writedata bits above WIDTH are architecturally ignored.
    assign unused_wdata = ^avs_writedata;

    // Synchroniser chain.
    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: accept a new level only after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge detection against the previous debounced value.
    always_comb begin
        stable_dly_d = stable_q;
        rise_c       = stable_q & ~stable_dly_q;
        fall_c       = ~stable_q & stable_dly_q;
        if (EDGE_MODE == 0) begin
            edge_sel_c = rise_c;
        end else if (EDGE_MODE == 1) begin
            edge_sel_c = fall_c;
        end else begin
            edge_sel_c = rise_c | fall_c;
        end
    end

    // Register file; a new edge wins over a simultaneous W1C clear.
    always_comb begin
        clr_c      = '0;
        irqmask_d  = irqmask_q;
        readdata_d = readdata_q;
        if (avs_write && (avs_address == ADDR_EDGE)) begin
            clr_c = avs_writedata[WIDTH-1:0];
        end
        if (avs_write && (avs_address == ADDR_MASK)) begin
            irqmask_d = avs_writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr_c) | edge_sel_c;
        irq_d     = |(edgecap_q & irqmask_q);
        if (avs_read) begin
            case (avs_address)
                ADDR_DATA: readdata_d = DATA_W'(stable_q);
                ADDR_MASK: readdata_d = DATA_W'(irqmask_q);
                ADDR_EDGE: readdata_d = DATA_W'(edgecap_q);
                default:   readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q      <= RST_VEC;
            sync2_q      <= RST_VEC;
            stable_q     <= RST_VEC;
            stable_dly_q <= RST_VEC;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
            irqmask_q    <= '0;
            edgecap_q    <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            irqmask_q    <= irqmask_d;
            edgecap_q    <= edgecap_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_key_pio_debounce.sv
// Bench for key_pio_debounce: falling-edge and any-edge instances share stimulus
// and are compared every clock against a window-based behavioural model.
module tb_key_pio_debounce;

    localparam int unsigned W   = 4;
    localparam int unsigned DEB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_in = 4'hF;
    logic [1:0]  bus_addr = 2'd0;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic [31:0] bus_wd = 32'h0;
    logic [31:0] rdata1, rdata2;
    logic        irq1, irq2;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: sync delay line, sample window since last reset, register images.
    logic [3:0]  m_pipe [2];
    logic [3:0]  win [$];
    logic [3:0]  m_stable, m_prev, m_mask;
    logic [3:0]  m_cap [2];
    logic        m_irq [2];
    logic [31:0] m_rd  [2];

    key_pio_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .CNT_W(4), .EDGE_MODE(1), .RESET_LEVEL(1'b1)) dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .key_in(key_in), .avs_address(bus_addr),
        .avs_read(bus_rd), .avs_write(bus_wr), .avs_writedata(bus_wd),
        .avs_readdata(rdata1), .irq(irq1));

    key_pio_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .CNT_W(4), .EDGE_MODE(2), .RESET_LEVEL(1'b1)) dut2 (
        .clk_clk(clk), .reset_reset_n(rst_n), .key_in(key_in), .avs_address(bus_addr),
        .avs_read(bus_rd), .avs_write(bus_wr), .avs_writedata(bus_wd),
        .avs_readdata(rdata2), .irq(irq2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pipe[0] = 4'hF;
        m_pipe[1] = 4'hF;
        win.delete();
        m_stable = 4'hF;
        m_prev   = 4'hF;
        m_mask   = 4'h0;
        for (int k = 0; k < 2; k++) begin
            m_cap[k] = 4'h0;
            m_irq[k] = 1'b0;
            m_rd[k]  = 32'h0;
        end
    endtask

    // One clock: predict from pre-edge inputs, advance, then compare both instances.
    task automatic tick();
        logic [3:0]  smp, n_st, rise, fall, ev, clr, tmp, n_mask, n_p0, n_p1;
        logic [3:0]  n_cap [2];
        logic        n_irq [2];
        logic [31:0] n_rd  [2];
        bit          all_diff;
        smp = m_pipe[1];
        win.push_back(smp);
        if (win.size() > DEB) void'(win.pop_front());
        n_st = m_stable;
        if (win.size() == DEB) begin
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                foreach (win[j]) begin
                    tmp = win[j];
                    if (tmp[b] == m_stable[b]) all_diff = 1'b0;
                end
                if (all_diff) n_st[b] = smp[b];
            end
        end
        rise = m_stable & ~m_prev;
        fall = ~m_stable & m_prev;
        clr  = (bus_wr && bus_addr == 2'd3) ? bus_wd[3:0] : 4'h0;
        for (int k = 0; k < 2; k++) begin
            ev       = (k == 0) ? fall : (rise | fall);
            n_irq[k] = |(m_cap[k] & m_mask);
            n_cap[k] = (m_cap[k] & ~clr) | ev;
            n_rd[k]  = m_rd[k];
            if (bus_rd) begin
                case (bus_addr)
                    2'd0:    n_rd[k] = {28'h0, m_stable};
                    2'd2:    n_rd[k] = {28'h0, m_mask};
                    2'd3:    n_rd[k] = {28'h0, m_cap[k]};
                    default: n_rd[k] = 32'h0;
                endcase
            end
        end
        n_mask = (bus_wr && bus_addr == 2'd2) ? bus_wd[3:0] : m_mask;
        n_p0   = key_in;
        n_p1   = m_pipe[0];
        @(posedge clk);
        #1;
        m_pipe[0] = n_p0;
        m_pipe[1] = n_p1;
        m_prev    = m_stable;
        m_stable  = n_st;
        m_mask    = n_mask;
        for (int k = 0; k < 2; k++) begin
            m_cap[k] = n_cap[k];
            m_irq[k] = n_irq[k];
            m_rd[k]  = n_rd[k];
        end
        chk("rdata_fall", rdata1, m_rd[0]);
        chk("rdata_any",  rdata2, m_rd[1]);
        chk("irq_fall",   {31'h0, irq1}, {31'h0, m_irq[0]});
        chk("irq_any",    {31'h0, irq2}, {31'h0, m_irq[1]});
    endtask

    task automatic idle(input int n);
        bus_rd = 1'b0;
        bus_wr = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_rd = 1'b0; bus_wr = 1'b1; bus_addr = a; bus_wd = d;
        tick();
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = a;
        tick();
        bus_rd = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdata_fall"}, rdata1, 32'h0);
        chk({tag, "_rdata_any"},  rdata2, 32'h0);
        chk({tag, "_irq_fall"},   {31'h0, irq1}, 32'h0);
        chk({tag, "_irq_any"},    {31'h0, irq2}, 32'h0);
    endtask

    initial begin
        model_reset();
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values through the bus.
        idle(3);
        bus_read(2'd0);
        chk("reset_data", rdata1, 32'h0000_000F);
        bus_read(2'd3);
        chk("reset_edgecap", rdata1, 32'h0);
        chk("reset_irq", {31'h0, irq1}, 32'h0);

        // Press key0: accepted exactly 2+8 clocks after the pin change.
        key_in = 4'hE;
        bus_rd = 1'b1; bus_addr = 2'd0;
        for (int i = 0; i < 10; i++) tick();
        chk("press_not_yet", rdata1, 32'h0000_000F);
        tick();
        chk("press_data", rdata1, 32'h0000_000E);
        bus_addr = 2'd3;
        tick();
        chk("press_edgecap", rdata1, 32'h1);
        chk("press_irq_masked", {31'h0, irq1}, 32'h0);
        idle(3);

        // Release, clear, then three short glitches that must be rejected.
        key_in = 4'hF;
        idle(15);
        bus_write(2'd3, 32'hF);
        for (int g = 0; g < 3; g++) begin
            key_in = 4'hE;
            idle(5);
            key_in = 4'hF;
            idle(10);
        end
        bus_read(2'd0);
        chk("glitch_data", rdata1, 32'h0000_000F);
        bus_read(2'd3);
        chk("glitch_edgecap", rdata1, 32'h0);

        // Interrupt path and W1C clear.
        bus_write(2'd2, 32'h1);
        key_in = 4'hE;
        for (int i = 0; i < 11; i++) tick();
        chk("irq_before", {31'h0, irq1}, 32'h0);
        tick();
        chk("irq_rise", {31'h0, irq1}, 32'h1);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3);
        chk("w1c_edgecap", rdata1, 32'h0);
        chk("w1c_irq", {31'h0, irq1}, 32'h0);

        // W1C collision with key1's detected falling edge: set wins.
        key_in = 4'hF;
        idle(15);
        bus_write(2'd3, 32'hF);
        key_in = 4'hD;
        idle(10);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3);
        chk("collision_bit1", {31'h0, rdata1[1]}, 32'h1);

        // Any-edge instance: key2 press and release each captured.
        key_in = 4'hF;
        idle(15);
        bus_write(2'd3, 32'hF);
        key_in = 4'hB;
        idle(20);
        bus_read(2'd3);
        chk("any_press_bit2", {31'h0, rdata2[2]}, 32'h1);
        chk("fall_press_bit2", {31'h0, rdata1[2]}, 32'h1);
        bus_write(2'd3, 32'hF);
        key_in = 4'hF;
        idle(20);
        bus_read(2'd3);
        chk("any_release_bit2", {31'h0, rdata2[2]}, 32'h1);
        chk("fall_release_bit2", {31'h0, rdata1[2]}, 32'h0);

        // Reset mid-count: outputs clear at once and release yields no edge.
        key_in = 4'hB;
        idle(6);
        key_in = 4'hF;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midcount");
        model_reset();
        #2;
        rst_n = 1'b1;
        idle(20);
        bus_read(2'd3);
        chk("post_reset_edge_fall", rdata1, 32'h0);
        chk("post_reset_edge_any",  rdata2, 32'h0);
        bus_read(2'd0);
        chk("post_reset_data", rdata1, 32'h0000_000F);

        // Randomised key activity and bus traffic against the model.
        for (int n = 0; n < 150; n++) begin
            int hold;
            key_in = 4'($urandom);
            hold   = $urandom_range(1, 14);
            for (int h = 0; h < hold; h++) begin
                bus_rd   = 1'($urandom);
                bus_wr   = ($urandom_range(0, 7) == 0);
                bus_addr = 2'($urandom);
                bus_wd   = $urandom;
                tick();
            end
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
